// File: rtl/mole_sched_pkg.sv
// Shared definitions for the mole scheduler.
// Contents: FSM state encoding, LFSR seed, LFSR tap mask and LFSR step helper.
package mole_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_UP   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One Fibonacci step: shift left, XOR of tapped bits enters at bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, reset to the package seed.
// Ports: clk_i clock, rst_ni async active-low reset, rnd_o low four state bits.
module lfsr16
  import mole_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [3:0] rnd_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR state, advanced every clock.
  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  // LFSR state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd_o = lfsr_q[3:0];

endmodule

// File: rtl/mole_sched.sv
// Whack-a-hole mole scheduler: picks a random hole after a random gap, keeps the
// mole up for a level-dependent time, and judges debounced button presses.
// Ports: clk clock; clr async active-low reset; start game start pulse;
// stop game-over level; hit[1:0] button levels; seq[1:0] lit hole (one-hot or 0);
// hit_ok / wrong / miss one-cycle result pulses; level[1:0] difficulty 0..3.
module mole_sched
  import mole_sched_pkg::*;
#(
  parameter int TICK_CYC       = 500000,
  parameter int GAP_BASE       = 30,
  parameter int UP_T0          = 100,
  parameter int UP_STEP        = 20,
  parameter int HITS_PER_LEVEL = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] hit,
  output logic [1:0] seq,
  output logic       hit_ok,
  output logic       wrong,
  output logic       miss,
  output logic [1:0] level
);

  localparam int DW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int HW = $clog2(HITS_PER_LEVEL + 1);
  localparam logic [15:0] GAP_BASE_W = 16'(GAP_BASE);
  localparam logic [15:0] UP_T0_W    = 16'(UP_T0);
  localparam logic [15:0] UP_STEP_W  = 16'(UP_STEP);

  logic [DW-1:0] div_q, div_d;
  logic          tick_s;
  logic [3:0]    rnd_s;
  logic [1:0]    hit_q;
  logic [1:0]    press_s;
  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [HW-1:0] hits_q, hits_d;
  logic [1:0]    seq_q, seq_d;
  logic          hit_ok_q, hit_ok_d;
  logic          wrong_q, wrong_d;
  logic          miss_q, miss_d;
  logic [1:0]    level_q, level_d;
  logic [15:0]   gap_load_s;
  logic [15:0]   up_load_s;

  lfsr16 u_lfsr (
    .clk_i  (clk),
    .rst_ni (clr),
    .rnd_o  (rnd_s)
  );

  assign tick_s     = (div_q == DW'(TICK_CYC - 1));
  assign div_d      = tick_s ? '0 : div_q + DW'(1);
  assign press_s    = hit & ~hit_q;
  assign gap_load_s = GAP_BASE_W + {12'd0, rnd_s};
  assign up_load_s  = UP_T0_W - (16'(level_q) * UP_STEP_W);

  // Next-state and output decode; stop outranks every other event.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    hits_d   = hits_q;
    level_d  = level_q;
    hit_ok_d = 1'b0;
    wrong_d  = 1'b0;
    miss_d   = 1'b0;
    if (stop && (state_q != ST_IDLE)) begin
      state_d = ST_DONE;
      seq_d   = 2'b00;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          seq_d = 2'b00;
          if (start) begin
            state_d = ST_GAP;
            cnt_d   = gap_load_s;
            level_d = 2'd0;
            hits_d  = '0;
          end else begin
            state_d = state_q;
          end
        end
        ST_GAP: begin
          seq_d = 2'b00;
          if (tick_s && (cnt_q == 16'd0)) begin
            state_d = ST_UP;
            cnt_d   = up_load_s;
            seq_d   = rnd_s[0] ? 2'b10 : 2'b01;
          end else if (tick_s) begin
            cnt_d = cnt_q - 16'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_UP: begin
          // A lit-hole press wins over an unlit press and over timeout.
          if ((press_s & seq_q) != 2'b00) begin
            hit_ok_d = 1'b1;
            seq_d    = 2'b00;
            state_d  = ST_GAP;
            cnt_d    = gap_load_s;
            if (hits_q == HW'(HITS_PER_LEVEL - 1)) begin
              hits_d  = '0;
              level_d = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
            end else begin
              hits_d = hits_q + HW'(1);
            end
          end else begin
            wrong_d = ((press_s & ~seq_q) != 2'b00);
            if (tick_s && (cnt_q == 16'd0)) begin
              miss_d  = 1'b1;
              seq_d   = 2'b00;
              state_d = ST_GAP;
              cnt_d   = gap_load_s;
            end else if (tick_s) begin
              cnt_d = cnt_q - 16'd1;
            end else begin
              cnt_d = cnt_q;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          seq_d   = 2'b00;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_q    <= '0;
      hit_q    <= 2'b00;
      state_q  <= ST_IDLE;
      cnt_q    <= 16'd0;
      hits_q   <= '0;
      seq_q    <= 2'b00;
      hit_ok_q <= 1'b0;
      wrong_q  <= 1'b0;
      miss_q   <= 1'b0;
      level_q  <= 2'd0;
    end else begin
      div_q    <= div_d;
      hit_q    <= hit;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hits_q   <= hits_d;
      seq_q    <= seq_d;
      hit_ok_q <= hit_ok_d;
      wrong_q  <= wrong_d;
      miss_q   <= miss_d;
      level_q  <= level_d;
    end
  end

  assign seq    = seq_q;
  assign hit_ok = hit_ok_q;
  assign wrong  = wrong_q;
  assign miss   = miss_q;
  assign level  = level_q;

endmodule

// File: tb/tb_mole_sched.sv
// Directed bench for mole_sched with small timing parameters.
module tb_mole_sched;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic       stop;
  logic [1:0] hit;
  logic [1:0] seq;
  logic       hit_ok;
  logic       wrong;
  logic       miss;
  logic [1:0] level;

  int checks   = 0;
  int failures = 0;
  int n_hit    = 0;
  int n_wrong  = 0;
  int n_miss   = 0;

  mole_sched #(
    .TICK_CYC       (4),
    .GAP_BASE       (5),
    .UP_T0          (20),
    .UP_STEP        (4),
    .HITS_PER_LEVEL (2)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .stop   (stop),
    .hit    (hit),
    .seq    (seq),
    .hit_ok (hit_ok),
    .wrong  (wrong),
    .miss   (miss),
    .level  (level)
  );

  always #5 clk = ~clk;

  // Pulse counters: each edge counts the value visible during the cycle before it.
  always @(posedge clk) begin
    if (hit_ok) n_hit++;
    if (wrong) n_wrong++;
    if (miss) n_miss++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while ((seq == 2'b00) && (n < 200)) begin
      step(1);
      n++;
    end
    check("rise_seen", {31'd0, seq != 2'b00}, 32'd1);
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    while ((seq != 2'b00) && (n < 300)) begin
      step(1);
      n++;
    end
    check("fall_seen", {31'd0, seq == 2'b00}, 32'd1);
  endtask

  initial begin
    int n;
    int bad;
    int m0, h0, w0;
    logic [1:0] s;
    int lvl_exp[7] = '{0, 1, 1, 2, 2, 3, 3};

    clr = 1'b0; start = 1'b0; stop = 1'b0; hit = 2'b00;
    step(3);
    check("rst_seq", {30'd0, seq}, 32'd0);
    check("rst_hit_ok", {31'd0, hit_ok}, 32'd0);
    check("rst_wrong", {31'd0, wrong}, 32'd0);
    check("rst_miss", {31'd0, miss}, 32'd0);
    check("rst_level", {30'd0, level}, 32'd0);
    clr = 1'b1;
    step(5);
    check("idle_seq", {30'd0, seq}, 32'd0);

    // First mole: gap of 6..21 ticks (21..84 cycles), up 21 ticks, then miss.
    start = 1'b1; step(1); start = 1'b0;
    wait_rise(n);
    check("gap_min", {31'd0, n >= 21}, 32'd1);
    check("gap_max", {31'd0, n <= 84}, 32'd1);
    check("seq_onehot", {31'd0, (seq == 2'b01) || (seq == 2'b10)}, 32'd1);
    wait_fall(n);
    check("up_len_l0", n, 32'd84);
    check("miss_pulse", {31'd0, miss}, 32'd1);
    step(1);
    check("miss_one_cycle", {31'd0, miss}, 32'd0);

    // Seven hits, each pressed 3 ticks after the mole rises.
    m0 = n_miss;
    for (int k = 0; k < 7; k++) begin
      wait_rise(n);
      step(12);
      s = seq;
      hit = s;
      step(1);
      check("hit_ok_pulse", {31'd0, hit_ok}, 32'd1);
      check("hit_seq_zero", {30'd0, seq}, 32'd0);
      check("hit_level", {30'd0, level}, lvl_exp[k]);
      hit = 2'b00;
      step(1);
      check("hit_ok_one_cycle", {31'd0, hit_ok}, 32'd0);
    end
    check("no_miss_on_hits", n_miss - m0, 32'd0);

    // Level 3 mole stays up 9 ticks.
    wait_rise(n);
    wait_fall(n);
    check("up_len_l3", n, 32'd36);
    check("miss_l3", {31'd0, miss}, 32'd1);

    // Stop together with a lit press: no pulse, game parks in DONE.
    wait_rise(n);
    h0 = n_hit;
    s = seq;
    stop = 1'b1;
    hit = s;
    step(1);
    check("stop_no_hit", {31'd0, hit_ok}, 32'd0);
    check("stop_seq", {30'd0, seq}, 32'd0);
    check("stop_no_miss", {31'd0, miss}, 32'd0);
    check("stop_level_kept", {30'd0, level}, 32'd3);
    stop = 1'b0;
    hit = 2'b00;
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      step(1);
      if (seq != 2'b00) bad++;
    end
    check("done_quiet", bad, 32'd0);
    check("done_no_hit", n_hit - h0, 32'd0);
    start = 1'b1; step(1); start = 1'b0;
    check("restart_level", {30'd0, level}, 32'd0);

    // Unlit press: wrong pulse, mole unchanged, later timeout still misses.
    wait_rise(n);
    step(2);
    s = seq;
    hit = ~s;
    step(1);
    check("wrong_pulse", {31'd0, wrong}, 32'd1);
    check("wrong_seq_kept", {30'd0, seq}, {30'd0, s});
    check("wrong_no_hit", {31'd0, hit_ok}, 32'd0);
    hit = 2'b00;
    step(1);
    check("wrong_one_cycle", {31'd0, wrong}, 32'd0);
    wait_fall(n);
    check("wrong_then_miss", {31'd0, miss}, 32'd1);

    // Both buttons held from the gap: nothing until release and re-press.
    hit = 2'b11;
    h0 = n_hit; w0 = n_wrong;
    wait_rise(n);
    step(20);
    check("hold_no_hit", n_hit - h0, 32'd0);
    check("hold_no_wrong", n_wrong - w0, 32'd0);
    check("hold_seq_up", {31'd0, seq != 2'b00}, 32'd1);
    hit = 2'b00;
    step(1);
    hit = 2'b11;
    step(1);
    check("both_hit_ok", {31'd0, hit_ok}, 32'd1);
    check("both_no_wrong", {31'd0, wrong}, 32'd0);
    step(10);
    check("both_one_hit", n_hit - h0, 32'd1);
    check("both_zero_wrong", n_wrong - w0, 32'd0);
    hit = 2'b00;

    // Mid-game clr clears outputs immediately.
    wait_rise(n);
    clr = 1'b0;
    #1;
    check("clr_seq", {30'd0, seq}, 32'd0);
    check("clr_level", {30'd0, level}, 32'd0);
    step(2);
    clr = 1'b1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mole_sched.md
# mole_sched

Randomised mole scheduler for the whack-a-hole game. It produces the per-hole mole pattern that the scoring stage consumes, and judges debounced button presses against the lit hole. It emits one-cycle hit/miss/wrong pulses toward the score counters and raises difficulty as hits accumulate. It sits between the button debouncer and the scorer, and takes the 60 s timer carry as its game-over input.

## Interface
Parameters:
- `TICK_CYC`, default 500000: `clk` cycles per game tick (10 ms at 50 MHz).
- `GAP_BASE`, default 30: minimum ticks with no mole lit between moles.
- `UP_T0`, default 100: ticks a mole stays up at level 0.
- `UP_STEP`, default 20: ticks removed per level. `UP_T0` must be greater than 3*`UP_STEP`.
- `HITS_PER_LEVEL`, default 8: hits needed to advance one level.

Ports:
- `clk` in 1: system clock.
- `clr` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that starts a game.
- `stop` in 1: game-over level (timer carry). Sampled every cycle.
- `hit` in 2: debounced button levels, bit k = hole k.
- `seq` out 2: mole visible per hole, one-hot or 0, registered.
- `hit_ok` out 1: one-cycle pulse, lit hole pressed.
- `wrong` out 1: one-cycle pulse, unlit hole pressed while a mole is up.
- `miss` out 1: one-cycle pulse, mole timed out.
- `level` out 2: current difficulty, 0..3.

## Operation
- **Tick divider.** Free-running counter 0..`TICK_CYC`-1. `tick` is high for one cycle at terminal count.
- **LFSR.** 16-bit Fibonacci, taps 16,14,13,11. Seed 16'hACE1. Advances every `clk` so the pattern depends on player timing. It is never reseeded except by `clr`.
- **Edge detect.** `hit_q` is `hit` delayed one cycle. A press is `hit & ~hit_q`.
- **FSM states:** IDLE, GAP, UP, DONE.
  - IDLE: `seq`=0. `start` moves to GAP, clears `level`, and clears the hit counter.
  - GAP: on entry, load `cnt` = `GAP_BASE` + lfsr[3:0]. Decrement on each `tick`. At `tick` with `cnt`=0, go to UP, and `seq` becomes one-hot of lfsr[0] (0 → 2'b01, 1 → 2'b10).
  - UP: on entry, load `cnt` = `UP_T0` − `level`*`UP_STEP`. Decrement on `tick`.
    - A press on the lit hole: pulse `hit_ok`, `seq` becomes 0, go to GAP.
    - A press only on the unlit hole: pulse `wrong` and stay in UP.
    - `tick` with `cnt`=0 and no valid press: pulse `miss`, `seq` becomes 0, go to GAP.
  - DONE: `seq`=0 and no pulses. `start` moves to GAP with `level` and the hit counter cleared.
- **Stop.** `stop`=1 in any state other than IDLE moves to DONE next cycle. It overrides every other event in that cycle, so no pulse is emitted.
- **Level.** Each `hit_ok` increments the hit counter. When it reaches `HITS_PER_LEVEL` it wraps to 0 and `level` increments, saturating at 3. A new level takes effect at the next UP entry.
- **Simultaneous events:**
  - Both holes pressed with one lit: `hit_ok` only.
  - Press and timeout in the same cycle: the press wins.
  - `start` in GAP or UP is ignored.

## Timing
- Reset values: `seq`=0, `hit_ok`=`wrong`=`miss`=0, `level`=0, state IDLE, LFSR=16'hACE1, divider=0, `hit_q`=0.
- Press latency: clock edge E samples `hit`=1 with `hit_q`=0. `hit_ok` (or `wrong`) is high for exactly the cycle after E, and `seq` reads 0 in that same cycle.
- `miss` and the change of `seq` both take effect in the cycle after the terminal tick.
- Mole up duration is (loaded `cnt`+1) ticks.
- Gap duration is `GAP_BASE`+1 to `GAP_BASE`+16 ticks.
- Mid-game `clr` returns everything to reset values immediately.
- A button held across a state change produces no new press; the player must release and press again.

## Structure
- Shared package: state encoding constants (IDLE/GAP/UP/DONE), LFSR seed, and tap mask.
- One natural sub-module, `lfsr16`: free-running, with async active-low reset to the seed. The divider, edge detect, and FSM stay in `mole_sched`.

## Test plan
Bench parameters: `TICK_CYC`=4, `GAP_BASE`=5, `UP_T0`=20, `UP_STEP`=4, `HITS_PER_LEVEL`=2.
- Reset, then `start` with no presses → first `seq` is nonzero 6..21 ticks after `start`. It stays up 21 ticks, then one `miss` pulse and `seq`=0.
- Press the lit hole 3 ticks after `seq` rises → `hit_ok` is high for 1 cycle, the cycle after the sampled edge, with `seq`=0 in that cycle. No `miss` follows.
- Press the unlit hole while a mole is up → one `wrong` pulse, `seq` unchanged. A later timeout still gives `miss`.
- 7 consecutive hits → `level` steps 0, 1, 2, 3 and holds at 3. Up time at level 3 is 9 ticks.
- Raise `stop` during UP in the same cycle as a lit-hole press → no `hit_ok`, state DONE, `seq`=0. A later `start` resets `level` to 0.
- Hold `hit`=2'b11 from before UP entry → no pulses. Release and press both → exactly one `hit_ok`.
